// File: rtl/icache_refill_ctrl.sv
// Instruction cache miss sequencer: captures stage-2 misses, requests whole lines
// from memory, assembles 32-bit beats and drives the cache fill write port.
//
// state | meaning
// IDLE  | no miss outstanding, fill port quiet
// REQ   | line request presented to memory, waiting for ready
// RECV  | collecting LINE_SIZE response beats into the line buffer
// FILL  | fill write presented to cache, held until neither stall nor flush
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module icache_refill_ctrl #(
  parameter int LINE_SIZE  = 2,
  parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   miss,
  input  logic [1:0][ADDR_WIDTH-1:0]   miss_addr,
  input  logic                         ext_stall,
  input  logic                         ext_flush,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [ADDR_WIDTH-1:0]        mem_req_addr,
  input  logic                         mem_resp_valid,
  input  logic [31:0]                  mem_resp_data,
  output logic [ADDR_WIDTH-1:0]        fetch_addr,
  output logic                         fetch_addr_valid,
  output logic [32*LINE_SIZE-1:0]      fetched_data,
  output logic                         refill_busy
);

  localparam int OFS = 2 + $clog2(LINE_SIZE);
  localparam int CW  = (LINE_SIZE > 1) ? $clog2(LINE_SIZE) : 1;
  localparam int LW  = 32 * LINE_SIZE;
  localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RECV = 2'd2,
    FILL = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_line_q, cur_line_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [ADDR_WIDTH-1:0]   pend_line_q, pend_line_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [LW-1:0]           line_buf_q, line_buf_d;

  logic [ADDR_WIDTH-1:0]   line0, line1;
  logic                    cap_valid;
  logic [ADDR_WIDTH-1:0]   cap_line;
  logic                    cap_taken;
  logic                    fill_load;

  function automatic logic [ADDR_WIDTH-1:0] line_of(input logic [ADDR_WIDTH-1:0] a);
    line_of = {a[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
  endfunction

  assign line0 = line_of(miss_addr[0]);
  assign line1 = line_of(miss_addr[1]);

  // A miss arriving while busy can only take an empty slot, and never for the line in flight.
  always_comb begin
    cap_valid = 1'b0;
    cap_line  = line0;
    if (state_q != IDLE && !ext_flush && !pend_valid_q) begin
      if (miss[0] && line0 != cur_line_q) begin
        cap_valid = 1'b1;
        cap_line  = line0;
      end else if (miss[1] && line1 != cur_line_q) begin
        cap_valid = 1'b1;
        cap_line  = line1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_line_d   = cur_line_q;
    pend_valid_d = pend_valid_q;
    pend_line_d  = pend_line_q;
    cnt_d        = cnt_q;
    line_buf_d   = line_buf_q;
    cap_taken    = 1'b0;

    case (state_q)
      IDLE: begin
        if ((|miss) && !ext_flush) begin
          state_d    = REQ;
          cur_line_d = miss[0] ? line0 : line1;
          if (miss[0] && miss[1] && line0 != line1) begin
            pend_valid_d = 1'b1;
            pend_line_d  = line1;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = RECV;
          cnt_d   = '0;
        end
      end
      RECV: begin
        if (mem_resp_valid) begin
          line_buf_d[{cnt_q, 5'd0} +: 32] = mem_resp_data;
          if (cnt_q == LAST_BEAT) begin
            state_d = FILL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FILL: begin
        if (!ext_stall && !ext_flush) begin
          if (pend_valid_q) begin
            state_d      = REQ;
            cur_line_d   = pend_line_q;
            pend_valid_d = 1'b0;
          end else if (cap_valid) begin
            // Slot was empty on the accept cycle: go straight to the new line.
            state_d    = REQ;
            cur_line_d = cap_line;
            cap_taken  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      if (ext_flush) begin
        pend_valid_d = 1'b0;
      end else if (cap_valid && !cap_taken) begin
        pend_valid_d = 1'b1;
        pend_line_d  = cap_line;
      end
    end
  end

  assign fill_load = (state_q == RECV) && (state_d == FILL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cur_line_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_line_q  <= '0;
      cnt_q        <= '0;
      line_buf_q   <= '0;
    end else begin
      state_q      <= state_d;
      cur_line_q   <= cur_line_d;
      pend_valid_q <= pend_valid_d;
      pend_line_q  <= pend_line_d;
      cnt_q        <= cnt_d;
      line_buf_q   <= line_buf_d;
    end
  end

  // Outputs are flops loaded from next-state values so nothing from the inputs leaks through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_valid    <= 1'b0;
      mem_req_addr     <= '0;
      fetch_addr       <= '0;
      fetch_addr_valid <= 1'b0;
      fetched_data     <= '0;
      refill_busy      <= 1'b0;
    end else begin
      mem_req_valid    <= (state_d == REQ);
      fetch_addr_valid <= (state_d == FILL);
      refill_busy      <= (state_d != IDLE);
      if (state_d == REQ) begin
        mem_req_addr <= cur_line_d;
      end
      if (fill_load) begin
        fetch_addr   <= cur_line_q;
        fetched_data <= line_buf_d;
      end
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl (LINE_SIZE=2, 32-bit addresses); every check
// is at an exact cycle offset from the miss cycle t.
module tb_icache_refill_ctrl;

  logic              clk;
  logic              reset;
  logic [1:0]        miss;
  logic [1:0][31:0]  miss_addr;
  logic              ext_stall;
  logic              ext_flush;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [31:0]       mem_req_addr;
  logic              mem_resp_valid;
  logic [31:0]       mem_resp_data;
  logic [31:0]       fetch_addr;
  logic              fetch_addr_valid;
  logic [63:0]       fetched_data;
  logic              refill_busy;

  int n_cmp = 0;
  int n_bad = 0;

  icache_refill_ctrl #(.LINE_SIZE(2), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .miss(miss), .miss_addr(miss_addr),
    .ext_stall(ext_stall), .ext_flush(ext_flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .fetch_addr(fetch_addr), .fetch_addr_valid(fetch_addr_valid),
    .fetched_data(fetched_data), .refill_busy(refill_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b want 0", mem_req_valid); end
    n_cmp++; if (mem_req_addr !== 32'h0) begin n_bad++; $display("FAIL rst_req_addr: got %h want 0", mem_req_addr); end
    n_cmp++; if (fetch_addr !== 32'h0) begin n_bad++; $display("FAIL rst_fetch_addr: got %h want 0", fetch_addr); end
    n_cmp++; if (fetch_addr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_fetch_valid: got %b want 0", fetch_addr_valid); end
    n_cmp++; if (fetched_data !== 64'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", fetched_data); end
    n_cmp++; if (refill_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", refill_busy); end
  endtask

  task automatic test_single_miss();
    miss = 2'b01; miss_addr[0] = 32'h0000_1234;
    step(); // t+1
    miss = 2'b00;
    n_cmp++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h0000_1230}) begin n_bad++; $display("FAIL single_req: got %b/%h want 1/00001230", mem_req_valid, mem_req_addr); end
    n_cmp++; if (refill_busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", refill_busy); end
    step(); // t+2
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL single_req_drop: got %b want 0", mem_req_valid); end
    mem_resp_valid = 1'b1; mem_resp_data = 32'hAAAA_0001;
    step(); // t+3
    mem_resp_data = 32'hAAAA_0002;
    step(); // t+4
    mem_resp_valid = 1'b0;
    n_cmp++; if ({fetch_addr_valid, fetch_addr} !== {1'b1, 32'h0000_1230}) begin n_bad++; $display("FAIL single_fill: got %b/%h want 1/00001230", fetch_addr_valid, fetch_addr); end
    n_cmp++; if (fetched_data !== 64'hAAAA_0002_AAAA_0001) begin n_bad++; $display("FAIL single_data: got %h want aaaa0002aaaa0001", fetched_data); end
    step(); // t+5
    n_cmp++; if ({fetch_addr_valid, refill_busy} !== 2'b00) begin n_bad++; $display("FAIL single_idle: got valid %b busy %b want 0 0", fetch_addr_valid, refill_busy); end
    n_cmp++; if (fetch_addr !== 32'h0000_1230) begin n_bad++; $display("FAIL single_hold: got %h want 00001230", fetch_addr); end
  endtask

  task automatic test_dual_distinct();
    miss = 2'b11; miss_addr[0] = 32'h100; miss_addr[1] = 32'h208;
    step(); // t+1
    miss = 2'b00;
    n_cmp++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h100}) begin n_bad++; $display("FAIL dual_req0: got %b/%h want 1/00000100", mem_req_valid, mem_req_addr); end
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h1111_1111;
    step();
    mem_resp_data = 32'h2222_2222;
    step(); // t+4
    mem_resp_valid = 1'b0;
    n_cmp++; if ({fetch_addr_valid, fetch_addr, fetched_data} !== {1'b1, 32'h100, 64'h2222_2222_1111_1111}) begin n_bad++; $display("FAIL dual_fill0: got %b/%h/%h", fetch_addr_valid, fetch_addr, fetched_data); end
    step(); // t+5
    n_cmp++; if ({mem_req_valid, mem_req_addr, fetch_addr_valid} !== {1'b1, 32'h208 & 32'hFFFF_FFF8, 1'b0}) begin n_bad++; $display("FAIL dual_req1: got %b/%h/%b want 1/00000208/0", mem_req_valid, mem_req_addr, fetch_addr_valid); end
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h3333_3333;
    step();
    mem_resp_data = 32'h4444_4444;
    step(); // t+8
    mem_resp_valid = 1'b0;
    n_cmp++; if ({fetch_addr_valid, fetch_addr, fetched_data} !== {1'b1, 32'h208, 64'h4444_4444_3333_3333}) begin n_bad++; $display("FAIL dual_fill1: got %b/%h/%h", fetch_addr_valid, fetch_addr, fetched_data); end
    step();
    n_cmp++; if (refill_busy !== 1'b0) begin n_bad++; $display("FAIL dual_idle: got busy %b want 0", refill_busy); end
  endtask

  task automatic test_dual_same();
    int reqs;
    miss = 2'b11; miss_addr[0] = 32'h100; miss_addr[1] = 32'h104;
    step();
    miss = 2'b00;
    n_cmp++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h100}) begin n_bad++; $display("FAIL same_req: got %b/%h want 1/00000100", mem_req_valid, mem_req_addr); end
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h5A5A_0001;
    step();
    mem_resp_data = 32'h5A5A_0002;
    step();
    mem_resp_valid = 1'b0;
    n_cmp++; if ({fetch_addr_valid, fetched_data} !== {1'b1, 64'h5A5A_0002_5A5A_0001}) begin n_bad++; $display("FAIL same_fill: got %b/%h", fetch_addr_valid, fetched_data); end
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (mem_req_valid) reqs++;
    end
    n_cmp++; if ({reqs, refill_busy} !== {32'd0, 1'b0}) begin n_bad++; $display("FAIL same_one_req: got extra reqs %0d busy %b want 0 0", reqs, refill_busy); end
  endtask

  task automatic test_backpressure();
    int fills, reqs;
    mem_req_ready = 1'b0;
    miss = 2'b01; miss_addr[0] = 32'h3004;
    step(); // t+1
    miss = 2'b00;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h3000}) begin n_bad++; $display("FAIL bp_req_hold%0d: got %b/%h want 1/00003000", i, mem_req_valid, mem_req_addr); end
      step();
    end
    n_cmp++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h3000}) begin n_bad++; $display("FAIL bp_req_last: got %b/%h want 1/00003000", mem_req_valid, mem_req_addr); end
    mem_req_ready = 1'b1;
    step(); // RECV
    mem_resp_valid = 1'b1; mem_resp_data = 32'hBEEF_0000;
    step();
    mem_resp_valid = 1'b0; mem_resp_data = 32'hDEAD_DEAD;
    step();
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hBEEF_0001; ext_stall = 1'b1;
    step(); // first FILL cycle
    mem_resp_valid = 1'b0;
    fills = 0; reqs = 0;
    for (int j = 0; j < 8; j++) begin
      if (j == 3) ext_stall = 1'b0;
      if (fetch_addr_valid) begin
        fills++;
        n_cmp++; if ({fetch_addr, fetched_data} !== {32'h3000, 64'hBEEF_0001_BEEF_0000}) begin n_bad++; $display("FAIL bp_fill_hold%0d: got %h/%h", j, fetch_addr, fetched_data); end
      end
      if (mem_req_valid) reqs++;
      step();
    end
    n_cmp++; if (fills !== 4) begin n_bad++; $display("FAIL bp_fill_cycles: got %0d want 4", fills); end
    n_cmp++; if ({reqs, refill_busy} !== {32'd0, 1'b0}) begin n_bad++; $display("FAIL bp_single: got reqs %0d busy %b want 0 0", reqs, refill_busy); end
  endtask

  task automatic test_flush();
    int reqs;
    miss = 2'b11; miss_addr[0] = 32'h400; miss_addr[1] = 32'h508;
    step();
    miss = 2'b00;
    n_cmp++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h400}) begin n_bad++; $display("FAIL flush_req: got %b/%h want 1/00000400", mem_req_valid, mem_req_addr); end
    step(); // RECV
    ext_flush = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'h5555_5555;
    step();
    ext_flush = 1'b0; mem_resp_data = 32'h6666_6666;
    step();
    mem_resp_valid = 1'b0;
    n_cmp++; if ({fetch_addr_valid, fetch_addr, fetched_data} !== {1'b1, 32'h400, 64'h6666_6666_5555_5555}) begin n_bad++; $display("FAIL flush_fill: got %b/%h/%h", fetch_addr_valid, fetch_addr, fetched_data); end
    reqs = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_req_valid) reqs++;
    end
    n_cmp++; if ({reqs, refill_busy} !== {32'd0, 1'b0}) begin n_bad++; $display("FAIL flush_pend_drop: got reqs %0d busy %b want 0 0", reqs, refill_busy); end
  endtask

  task automatic test_reset_mid();
    miss = 2'b01; miss_addr[0] = 32'h604;
    step();
    miss = 2'b00;
    step(); // RECV
    mem_resp_valid = 1'b1; mem_resp_data = 32'h7777_7777;
    step();
    mem_resp_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_cmp++; if ({mem_req_valid, mem_req_addr, fetch_addr_valid, fetch_addr, refill_busy} !== {1'b0, 32'h0, 1'b0, 32'h0, 1'b0}) begin n_bad++; $display("FAIL midrst_outs: got %b/%h/%b/%h/%b want all 0", mem_req_valid, mem_req_addr, fetch_addr_valid, fetch_addr, refill_busy); end
    n_cmp++; if (fetched_data !== 64'h0) begin n_bad++; $display("FAIL midrst_data: got %h want 0", fetched_data); end
    step();
    reset = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h9999_9999;
    step();
    step();
    mem_resp_valid = 1'b0;
    n_cmp++; if ({mem_req_valid, fetch_addr_valid, refill_busy} !== 3'b000) begin n_bad++; $display("FAIL midrst_stray: got %b%b%b want 000", mem_req_valid, fetch_addr_valid, refill_busy); end
    miss = 2'b01; miss_addr[0] = 32'h704;
    step();
    miss = 2'b00;
    n_cmp++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h700}) begin n_bad++; $display("FAIL midrst_req: got %b/%h want 1/00000700", mem_req_valid, mem_req_addr); end
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hA1A1_A1A1;
    step();
    mem_resp_data = 32'hA2A2_A2A2;
    step();
    mem_resp_valid = 1'b0;
    n_cmp++; if ({fetch_addr_valid, fetch_addr, fetched_data} !== {1'b1, 32'h700, 64'hA2A2_A2A2_A1A1_A1A1}) begin n_bad++; $display("FAIL midrst_fill: got %b/%h/%h", fetch_addr_valid, fetch_addr, fetched_data); end
    step();
  endtask

  task automatic test_miss_busy();
    int reqs;
    miss = 2'b01; miss_addr[0] = 32'h800;
    step(); // t+1, REQ
    miss = 2'b10; miss_addr[1] = 32'h904;
    n_cmp++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h800}) begin n_bad++; $display("FAIL busy_req0: got %b/%h want 1/00000800", mem_req_valid, mem_req_addr); end
    step(); // t+2, RECV
    miss = 2'b01; miss_addr[0] = 32'hA00;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hC0C0_0001;
    step();
    miss = 2'b00; mem_resp_data = 32'hC0C0_0002;
    step(); // t+4
    mem_resp_valid = 1'b0;
    n_cmp++; if ({fetch_addr_valid, fetch_addr, fetched_data} !== {1'b1, 32'h800, 64'hC0C0_0002_C0C0_0001}) begin n_bad++; $display("FAIL busy_fill0: got %b/%h/%h", fetch_addr_valid, fetch_addr, fetched_data); end
    step(); // t+5
    n_cmp++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h900}) begin n_bad++; $display("FAIL busy_req1: got %b/%h want 1/00000900", mem_req_valid, mem_req_addr); end
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hD0D0_0001;
    step();
    mem_resp_data = 32'hD0D0_0002;
    step(); // t+8
    mem_resp_valid = 1'b0;
    n_cmp++; if ({fetch_addr_valid, fetch_addr, fetched_data} !== {1'b1, 32'h900, 64'hD0D0_0002_D0D0_0001}) begin n_bad++; $display("FAIL busy_fill1: got %b/%h/%h", fetch_addr_valid, fetch_addr, fetched_data); end
    reqs = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_req_valid) reqs++;
    end
    n_cmp++; if ({reqs, refill_busy} !== {32'd0, 1'b0}) begin n_bad++; $display("FAIL busy_drop4: got reqs %0d busy %b want 0 0", reqs, refill_busy); end
  endtask

  initial begin
    reset = 1'b0;
    miss = 2'b00;
    miss_addr = '0;
    ext_stall = 1'b0;
    ext_flush = 1'b0;
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data = 32'h0;
    step();
    step();
    test_reset();
    reset = 1'b1;
    step();
    test_single_miss();
    step();
    test_dual_distinct();
    step();
    test_dual_same();
    step();
    test_backpressure();
    step();
    test_flush();
    step();
    test_reset_mid();
    step();
    test_miss_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
